// File: rtl/cart_bus_pkg.sv
// Shared definitions for the cartridge bus responder: FSM encoding, default
// bus-cycle timing and the chip-select address window.
package cart_bus_pkg;

    localparam int CNT_W          = 4;
    localparam int SETUP_CYC_DEF  = 2;
    localparam int ACCESS_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF   = 1;

    localparam logic [15:0] CART_CS_LO = 16'hA000;
    localparam logic [15:0] CART_CS_HI = 16'hFDFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD
    } state_e;

    // External RAM / echo region decoded onto the cartridge CS pin.
    function automatic logic in_cs_window(input logic [15:0] addr);
        return (addr >= CART_CS_LO) && (addr <= CART_CS_HI);
    endfunction

endpackage

// File: rtl/cart_bus_ctrl_if.sv
// Request/response handshake between internal ROM readers (master) and the
// cartridge bus responder (slave).
interface cart_bus_ctrl_if;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic        rom_wr;
    logic [7:0]  rom_wdata;
    logic [7:0]  rom_data;
    logic        rom_bsy;
    logic        req_drop;

    modport master (
        output rom_addr, rom_rd, rom_wr, rom_wdata,
        input  rom_data, rom_bsy, req_drop
    );

    modport slave (
        input  rom_addr, rom_rd, rom_wr, rom_wdata,
        output rom_data, rom_bsy, req_drop
    );
endinterface

// File: rtl/cart_bus_ctrl.sv
// Runs one timed DMG-style cartridge bus cycle per accepted request and
// returns the read byte; all cartridge pins are driven from flops.
module cart_bus_ctrl
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int ACCESS_CYC = ACCESS_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
    input  logic                  clk_8m,
    input  logic                  rst_n,
    cart_bus_ctrl_if.slave        bus,
    output logic [15:0]           cart_a,
    input  logic [7:0]            cart_d_in,
    output logic [7:0]            cart_d_out,
    output logic                  cart_d_oe,
    output logic                  cart_rd_n,
    output logic                  cart_wr_n,
    output logic                  cart_cs_n
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_wr_q, dir_wr_d;
    logic [15:0]        cart_a_q, cart_a_d;
    logic [7:0]         cart_d_out_q, cart_d_out_d;
    logic               cart_d_oe_q, cart_d_oe_d;
    logic               cart_rd_n_q, cart_rd_n_d;
    logic               cart_wr_n_q, cart_wr_n_d;
    logic               cart_cs_n_q, cart_cs_n_d;
    logic [7:0]         rom_data_q, rom_data_d;
    logic               req_drop_q, req_drop_d;

    logic req_any;
    logic accept;
    logic busy_next;

    assign req_any = bus.rom_rd | bus.rom_wr;
    assign accept  = (state_q == ST_IDLE) && req_any;

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dir_wr_q     <= 1'b0;
            cart_a_q     <= '0;
            cart_d_out_q <= '0;
            cart_d_oe_q  <= 1'b0;
            cart_rd_n_q  <= 1'b1;
            cart_wr_n_q  <= 1'b1;
            cart_cs_n_q  <= 1'b1;
            rom_data_q   <= '0;
            req_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dir_wr_q     <= dir_wr_d;
            cart_a_q     <= cart_a_d;
            cart_d_out_q <= cart_d_out_d;
            cart_d_oe_q  <= cart_d_oe_d;
            cart_rd_n_q  <= cart_rd_n_d;
            cart_wr_n_q  <= cart_wr_n_d;
            cart_cs_n_q  <= cart_cs_n_d;
            rom_data_q   <= rom_data_d;
            req_drop_q   <= req_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_W'(ACCESS_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin flops are loaded from the next-state view so each pin changes on the
    // same edge as the state it belongs to.
    always_comb begin
        dir_wr_d     = accept ? ~bus.rom_rd : dir_wr_q;
        cart_a_d     = accept ? bus.rom_addr : cart_a_q;
        cart_d_out_d = (accept && !bus.rom_rd) ? bus.rom_wdata : cart_d_out_q;
        busy_next    = (state_d != ST_IDLE);
        cart_cs_n_d  = ~(busy_next && in_cs_window(cart_a_d));
        cart_d_oe_d  = busy_next && dir_wr_d;
        cart_rd_n_d  = ~((state_d == ST_ACCESS) && !dir_wr_d);
        cart_wr_n_d  = ~((state_d == ST_ACCESS) && dir_wr_d);
        rom_data_d   = rom_data_q;
        if ((state_q == ST_ACCESS) && (cnt_q == '0) && !dir_wr_q) begin
            rom_data_d = cart_d_in;
        end
        // Busy collision, or the write half of a simultaneous read+write.
        req_drop_d = ((state_q != ST_IDLE) && req_any) ||
                     ((state_q == ST_IDLE) && bus.rom_rd && bus.rom_wr);
    end

    assign bus.rom_bsy  = (state_q != ST_IDLE) | req_any;
    assign bus.rom_data = rom_data_q;
    assign bus.req_drop = req_drop_q;
    assign cart_a       = cart_a_q;
    assign cart_d_out   = cart_d_out_q;
    assign cart_d_oe    = cart_d_oe_q;
    assign cart_rd_n    = cart_rd_n_q;
    assign cart_wr_n    = cart_wr_n_q;
    assign cart_cs_n    = cart_cs_n_q;

endmodule
